// File: rtl/sram_controller.sv
// 32-bit word load/store responder for the MEM stage, split into two 16-bit
// accesses on an asynchronous SRAM with ACCESS_CYC clocks per half.
//
// state | meaning
// IDLE  | waiting for rd_en/wr_en; ready is ~(rd_en|wr_en)
// LO    | low half-word access at {idx,0}, ACCESS_CYC cycles
// HI    | high half-word access at {idx,1}, ACCESS_CYC cycles
// DONE  | one-cycle completion, ready=1, then back to IDLE
module sram_controller #(
    parameter int ADDR_W     = 18,
    parameter int BASE_ADDR  = 1024,
    parameter int ACCESS_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYC - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              op_wr;
    logic [ADDR_W-2:0] idx;
    logic [15:0]       wdata_hi;
    logic [31:0]       offs;
    logic [ADDR_W-2:0] req_idx;
    logic              req;
    logic              last;
    logic              busy;
    logic              unused_addr_bits;

    // Subtraction wraps naturally, so addresses below BASE_ADDR alias high words.
    assign offs             = address - 32'(BASE_ADDR);
    assign req_idx          = offs[ADDR_W:2];
    assign unused_addr_bits = ^{offs[31:ADDR_W+1], offs[1:0]};
    assign req              = rd_en | wr_en;
    assign last             = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ready      = 1'b0;
        busy       = 1'b0;
        sram_dq_oe = 1'b0;
        sram_we_n  = 1'b1;
        sram_oe_n  = 1'b1;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) state_nxt = LO;
            end
            LO: begin
                busy = 1'b1;
                if (last) state_nxt = HI;
            end
            HI: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Strobes decode only registered state so an async reset clears them at once.
        if (busy) begin
            sram_dq_oe = op_wr;
            sram_we_n  = ~(op_wr & ~last);
            sram_oe_n  = op_wr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            op_wr       <= 1'b0;
            idx         <= '0;
            wdata_hi    <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr       <= wr_en;
                        idx         <= req_idx;
                        wdata_hi    <= write_data[31:16];
                        cnt         <= '0;
                        sram_addr   <= {req_idx, 1'b0};
                        sram_dq_out <= write_data[15:0];
                    end
                end
                LO: begin
                    if (last) begin
                        cnt         <= '0;
                        sram_addr   <= {idx, 1'b1};
                        sram_dq_out <= wdata_hi;
                        if (!op_wr) read_data[15:0] <= sram_dq_in;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HI: begin
                    if (last) begin
                        cnt <= '0;
                        if (!op_wr) read_data[31:16] <= sram_dq_in;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
